// File: rtl/fifo_ctrl_pkg.sv
// Shared types and helpers for the FIFO read-side burst controller.
package fifo_ctrl_pkg;

    localparam int unsigned DATA_W  = 64;
    localparam int unsigned USEDW_W = 8;
    localparam int unsigned LVL_W   = USEDW_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    typedef struct packed {
        logic              sop;
        logic              eop;
        logic [DATA_W-1:0] data;
    } beat_t;

    // rdusedw wraps to 0 at full; rebuild the true level with one extra bit.
    function automatic logic [LVL_W-1:0] eff_level(input logic [USEDW_W-1:0] usedw,
                                                   input logic               full);
        if (full) begin
            return {1'b1, USEDW_W'(0)};
        end
        return {1'b0, usedw};
    endfunction

endpackage

// File: rtl/fifo_out_skid.sv
// Two-entry in-order valid/ready buffer; holds its head stable while stalled.
module fifo_out_skid
    import fifo_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  beat_t      din,
    output logic       valid,
    input  logic       ready,
    output beat_t      dout,
    output logic [1:0] occ
);

    beat_t      head;
    beat_t      tail;
    logic [1:0] cnt;
    logic [1:0] cnt_nxt;
    logic       pop;

    assign pop  = valid && ready;
    assign dout = head;
    assign occ  = cnt;

    always_comb begin
        cnt_nxt = cnt + 2'(push) - 2'(pop);
    end

    // Head is zeroed when the buffer empties so idle outputs read as 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= 2'd0;
            valid <= 1'b0;
            head  <= '0;
            tail  <= '0;
        end else begin
            cnt   <= cnt_nxt;
            valid <= (cnt_nxt != 2'd0);
            if (pop) begin
                if (cnt == 2'd2) begin
                    head <= tail;
                    if (push) begin
                        tail <= din;
                    end
                end else if (push) begin
                    head <= din;
                end else begin
                    head <= '0;
                end
            end else if (push) begin
                if (cnt == 2'd0) begin
                    head <= din;
                end else begin
                    tail <= din;
                end
            end
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains the dual-clock FIFO in framed bursts onto a valid/ready stream.
module fifo_burst_reader
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned USEDW_W     = 8,
    parameter int unsigned BURST_LEN   = 32,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic               rdclk,
    input  logic               aclr_n,
    input  logic               enable,
    input  logic [DATA_W-1:0]  fifo_q,
    input  logic [USEDW_W-1:0] fifo_rdusedw,
    input  logic               fifo_rdempty,
    input  logic               fifo_rdfull,
    output logic               fifo_rdreq,
    output logic [DATA_W-1:0]  m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_sop,
    output logic               m_eop,
    output logic               busy,
    output logic               full_seen,
    input  logic               clr_full_seen,
    output logic [31:0]        burst_cnt
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);

    rd_state_t        state, state_nxt;
    logic [CNT_W-1:0] blen, blen_nxt;
    logic [CNT_W-1:0] issued, issued_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic [LVL_W-1:0] lvl;
    logic             start;
    logic             infl, infl_sop, infl_eop;
    logic [1:0]       occ;
    logic             pop;
    logic             eop_acc;
    logic             can_read;
    beat_t            push_beat;
    beat_t            out_beat;

    assign lvl     = eff_level(fifo_rdusedw, fifo_rdfull);
    assign pop     = m_valid && m_ready;
    assign eop_acc = pop && m_eop;
    // A slot freed by this cycle's handshake counts, giving 1 word/cycle.
    assign can_read = (3'(occ) + 3'(infl)) < (3'd2 + 3'(pop));
    assign start    = enable && ((lvl >= LVL_W'(BURST_LEN)) ||
                                 ((lvl != '0) && (timer == TMR_W'(TIMEOUT_CYC))));

    always_comb begin
        state_nxt  = state;
        blen_nxt   = blen;
        issued_nxt = issued;
        timer_nxt  = timer;
        fifo_rdreq = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt  = BURST;
                    blen_nxt   = (lvl >= LVL_W'(BURST_LEN)) ? CNT_W'(BURST_LEN) : CNT_W'(lvl);
                    issued_nxt = '0;
                    timer_nxt  = '0;
                end else if ((lvl == '0) || (lvl >= LVL_W'(BURST_LEN))) begin
                    timer_nxt = '0;
                end else if (timer != TMR_W'(TIMEOUT_CYC)) begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end
            BURST: begin
                fifo_rdreq = !fifo_rdempty && (issued < blen) && can_read;
                if (fifo_rdreq) begin
                    issued_nxt = issued + CNT_W'(1);
                    if (issued_nxt == blen) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (eop_acc) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge rdclk or negedge aclr_n) begin
        if (!aclr_n) begin
            state     <= IDLE;
            blen      <= '0;
            issued    <= '0;
            timer     <= '0;
            infl      <= 1'b0;
            infl_sop  <= 1'b0;
            infl_eop  <= 1'b0;
            busy      <= 1'b0;
            full_seen <= 1'b0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            blen      <= blen_nxt;
            issued    <= issued_nxt;
            timer     <= timer_nxt;
            infl      <= fifo_rdreq;
            infl_sop  <= (issued == '0);
            infl_eop  <= (issued == blen - CNT_W'(1));
            busy      <= (state_nxt != IDLE);
            full_seen <= fifo_rdfull ? 1'b1 : (clr_full_seen ? 1'b0 : full_seen);
            burst_cnt <= burst_cnt + 32'(eop_acc);
        end
    end

    // Read data appears on fifo_q the cycle after the strobe, tagged at issue.
    always_comb begin
        push_beat      = '0;
        push_beat.sop  = infl_sop;
        push_beat.eop  = infl_eop;
        push_beat.data = fifo_q;
    end

    fifo_out_skid u_skid (
        .clk   (rdclk),
        .rst_n (aclr_n),
        .push  (infl),
        .din   (push_beat),
        .valid (m_valid),
        .ready (m_ready),
        .dout  (out_beat),
        .occ   (occ)
    );

    assign m_data = out_beat.data;
    assign m_sop  = out_beat.sop;
    assign m_eop  = out_beat.eop;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench: FIFO model, stream scoreboard with burst framing, directed scenarios.
module tb_fifo_burst_reader;

    logic        rdclk = 1'b0;
    logic        aclr_n = 1'b1;
    logic        enable = 1'b0;
    logic [63:0] fifo_q = '0;
    logic [7:0]  fifo_rdusedw = '0;
    logic        fifo_rdempty = 1'b1;
    logic        fifo_rdfull = 1'b0;
    logic        fifo_rdreq;
    logic [63:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic        m_sop, m_eop, busy, full_seen;
    logic        clr_full_seen = 1'b0;
    logic [31:0] burst_cnt;

    fifo_burst_reader #(
        .DATA_W(64), .USEDW_W(8), .BURST_LEN(32), .TIMEOUT_CYC(1024)
    ) dut (
        .rdclk(rdclk), .aclr_n(aclr_n), .enable(enable), .fifo_q(fifo_q),
        .fifo_rdusedw(fifo_rdusedw), .fifo_rdempty(fifo_rdempty), .fifo_rdfull(fifo_rdfull),
        .fifo_rdreq(fifo_rdreq), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_sop(m_sop), .m_eop(m_eop), .busy(busy), .full_seen(full_seen),
        .clr_full_seen(clr_full_seen), .burst_cnt(burst_cnt)
    );

    always #5 rdclk = ~rdclk;

    logic [63:0] fifo_mem[$];
    logic [63:0] exp_q[$];
    int          blen_q[$];
    int          checks = 0, errors = 0;
    int          cyc = 0, rd_total = 0, acc_total = 0, idx = 0;
    int          bursts_done = 0, last_eop_cyc = 0, seq = 0;
    logic        rd_latched = 1'b0, lfsr_mode = 1'b0, prev_stall = 1'b0;
    logic [15:0] lfsr = 16'hACE1;
    logic [63:0] prev_data = '0;
    logic        prev_sop = 1'b0, prev_eop = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void set_flags();
        fifo_rdusedw = 8'(fifo_mem.size());
        fifo_rdfull  = (fifo_mem.size() == 256);
        fifo_rdempty = (fifo_mem.size() == 0);
    endfunction

    task automatic preload(input int n);
        for (int i = 0; i < n; i++) begin
            logic [63:0] w;
            w = {16'hBEEF, 16'(seq), 32'(seq) * 32'h9E37_79B9};
            fifo_mem.push_back(w);
            exp_q.push_back(w);
            seq++;
        end
        set_flags();
    endtask

    task automatic tick();
        @(negedge rdclk);
        #1;
    endtask

    task automatic wait_bursts(input int n, input int bound);
        int k = 0;
        while (bursts_done < n && k < bound) begin
            tick();
            k++;
        end
        check("bursts_done", 64'(bursts_done), 64'(n));
    endtask

    task automatic wait_rd(input int bound, input string nm);
        int k = 0;
        while (!fifo_rdreq && k < bound) begin
            tick();
            k++;
        end
        check(nm, 64'(fifo_rdreq), 64'd1);
    endtask

    // FIFO read port and m_ready source, updated just after each active edge.
    always begin
        @(posedge rdclk);
        #1;
        if (rd_latched && fifo_mem.size() > 0) begin
            fifo_q = fifo_mem.pop_front();
            set_flags();
        end
        rd_latched = 1'b0;
        lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        m_ready = lfsr_mode ? lfsr[0] : 1'b1;
    end

    // Compare process: stream order, framing, stall stability, credit bound.
    always @(negedge rdclk) begin
        cyc++;
        if (!aclr_n) begin
            rd_latched = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_ctl", {61'd0, m_valid, m_sop, m_eop}, {61'd0, 1'b1, prev_sop, prev_eop});
                check("hold_data", m_data, prev_data);
            end
            if (fifo_rdreq) begin
                check("rd_when_empty", 64'(fifo_rdempty), 64'd0);
                rd_latched = 1'b1;
                rd_total++;
            end
            if (m_valid && m_ready) begin
                acc_total++;
                if (exp_q.size() == 0 || blen_q.size() == 0) begin
                    check("unexpected_word", 64'd1, 64'd0);
                end else begin
                    logic [63:0] ex;
                    int          bl;
                    ex = exp_q.pop_front();
                    bl = blen_q[0];
                    check("data", m_data, ex);
                    check("sop", 64'(m_sop), 64'(idx == 0));
                    check("eop", 64'(m_eop), 64'(idx == bl - 1));
                    idx++;
                    if (idx == bl) begin
                        idx = 0;
                        void'(blen_q.pop_front());
                        bursts_done++;
                        last_eop_cyc = cyc;
                    end
                end
            end
            check("credit", 64'((rd_total - acc_total) <= 2), 64'd1);
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_sop   = m_sop;
            prev_eop   = m_eop;
        end
    end

    initial begin
        int t0, t1, lost;
        #1 aclr_n = 1'b0;
        #2;
        check("rst_rdreq", 64'(fifo_rdreq), 64'd0);
        check("rst_valid", 64'(m_valid), 64'd0);
        check("rst_sop", 64'(m_sop), 64'd0);
        check("rst_eop", 64'(m_eop), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_full_seen", 64'(full_seen), 64'd0);
        check("rst_burst_cnt", 64'(burst_cnt), 64'd0);
        @(negedge rdclk);
        aclr_n = 1'b1;
        repeat (2) tick();

        // 40 words: one full burst, latency 2 from first strobe to first valid
        preload(40);
        blen_q.push_back(32);
        blen_q.push_back(8);
        tick();
        check("idle_disabled", 64'(busy), 64'd0);
        enable = 1'b1;
        wait_rd(20, "first_rdreq");
        t0 = cyc;
        begin
            int k = 0;
            while (!m_valid && k < 20) begin
                tick();
                k++;
            end
        end
        t1 = cyc;
        check("first_latency", 64'(t1 - t0), 64'd2);
        wait_bursts(1, 200);
        tick();
        check("burst_cnt_1", 64'(burst_cnt), 64'd1);
        check("level_after_1", 64'(fifo_mem.size()), 64'd8);
        check("busy_after_1", 64'(busy), 64'd0);

        // 8 leftover words start a partial burst once the idle timer expires
        wait_rd(1100, "timeout_rdreq");
        check("timeout_gap", 64'(cyc - last_eop_cyc), 64'd1026);
        wait_bursts(2, 60);
        tick();
        check("burst_cnt_2", 64'(burst_cnt), 64'd2);
        check("empty_after_2", 64'(fifo_rdempty), 64'd1);

        // Random backpressure; enable dropped mid-burst must not truncate
        lfsr_mode = 1'b1;
        preload(32);
        blen_q.push_back(32);
        wait_rd(20, "lfsr_rdreq");
        enable = 1'b0;
        wait_bursts(3, 500);
        lfsr_mode = 1'b0;
        repeat (2) tick();
        check("burst_cnt_3", 64'(burst_cnt), 64'd3);
        check("busy_after_3", 64'(busy), 64'd0);

        // Full FIFO (rdusedw wrapped to 0) and sticky full flag
        preload(256);
        repeat (2) tick();
        check("full_seen_set", 64'(full_seen), 64'd1);
        check("full_no_start", 64'(busy), 64'd0);
        clr_full_seen = 1'b1;
        tick();
        clr_full_seen = 1'b0;
        check("full_set_wins", 64'(full_seen), 64'd1);
        for (int i = 0; i < 8; i++) blen_q.push_back(32);
        enable = 1'b1;
        begin
            int k = 0;
            while (fifo_mem.size() == 256 && k < 20) begin
                tick();
                k++;
            end
        end
        check("full_burst_started", 64'(busy), 64'd1);
        clr_full_seen = 1'b1;
        tick();
        clr_full_seen = 1'b0;
        check("full_seen_clr", 64'(full_seen), 64'd0);
        wait_bursts(11, 1000);
        tick();
        check("burst_cnt_11", 64'(burst_cnt), 64'd11);

        // A single word forced out by the timeout carries both sop and eop
        preload(1);
        blen_q.push_back(1);
        wait_bursts(12, 1200);
        tick();
        check("burst_cnt_12", 64'(burst_cnt), 64'd12);

        // Reset after the 10th word of a burst; FIFO keeps its contents
        preload(50);
        blen_q.push_back(32);
        begin
            int k = 0;
            while (idx < 10 && k < 100) begin
                tick();
                k++;
            end
        end
        @(posedge rdclk);
        #3 aclr_n = 1'b0;
        #1;
        check("mid_rst_rdreq", 64'(fifo_rdreq), 64'd0);
        check("mid_rst_valid", 64'(m_valid), 64'd0);
        check("mid_rst_sop_eop", {62'd0, m_sop, m_eop}, 64'd0);
        check("mid_rst_data", m_data, 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_burst_cnt", 64'(burst_cnt), 64'd0);
        check("mid_rst_level", 64'(fifo_mem.size()), 64'd38);
        lost = rd_total - acc_total;
        for (int i = 0; i < lost; i++) void'(exp_q.pop_front());
        rd_total = 0;
        acc_total = 0;
        idx = 0;
        blen_q.delete();
        blen_q.push_back(32);
        blen_q.push_back(6);
        repeat (2) @(negedge rdclk);
        aclr_n = 1'b1;
        tick();
        check("post_rst_start", 64'(busy), 64'd1);
        wait_bursts(14, 1400);
        tick();
        check("burst_cnt_post_rst", 64'(burst_cnt), 64'd2);
        check("all_delivered", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
Read-side controller for the 64-bit dual-clock FIFO, running in the FIFO's read clock domain. It watches rdusedw/rdempty/rdfull and drains the FIFO in framed bursts onto a valid/ready stream. A burst starts when BURST_LEN words are available, or when a partial burst has waited TIMEOUT_CYC cycles. It hides the FIFO's 1-cycle read latency behind a 2-entry output buffer, so downstream backpressure never drops or duplicates a word.

Parameters:
DATA_W, 64, FIFO word width
USEDW_W, 8, width of fifo_rdusedw
BURST_LEN, 32, words per full burst; legal range 2..255
TIMEOUT_CYC, 1024, idle cycles with 0 < level < BURST_LEN before a partial burst is forced

Ports:
rdclk  in  1  FIFO read clock; the only clock of this block
aclr_n  in  1  asynchronous active-low reset
enable  in  1  allows new bursts to start
fifo_q  in  DATA_W  FIFO read data, valid 1 cycle after fifo_rdreq
fifo_rdusedw  in  USEDW_W  FIFO fill level (wraps to 0 when full)
fifo_rdempty  in  1  FIFO empty
fifo_rdfull  in  1  FIFO full
fifo_rdreq  out  1  FIFO read strobe
m_data  out  DATA_W  stream data
m_valid  out  1  stream valid
m_ready  in  1  stream ready
m_sop  out  1  first word of burst
m_eop  out  1  last word of burst
busy  out  1  a burst is in progress (state != IDLE)
full_seen  out  1  sticky: fifo_rdfull was observed high
clr_full_seen  in  1  clears full_seen
burst_cnt  out  32  completed bursts; wraps modulo 2^32

Behaviour:
- Reset (aclr_n low, asynchronous): state IDLE; fifo_rdreq, m_valid, m_sop, m_eop, busy, full_seen = 0; burst_cnt, timer, counters and buffer = 0. Release is synchronous to rdclk. A reset mid-burst discards in-flight and buffered words; the FIFO contents are not touched.
- Effective level: lvl = 2^USEDW_W when fifo_rdfull = 1, else fifo_rdusedw. This covers rdusedw wrap-around at full.
- States:
  - IDLE -> BURST when enable && (lvl >= BURST_LEN || (lvl != 0 && timer == TIMEOUT_CYC)).
    - Snapshot burst length: blen = min(lvl, BURST_LEN). Clear timer and issued/sent counters.
  - BURST -> DRAIN on the cycle the blen-th fifo_rdreq is issued.
  - DRAIN -> IDLE on the cycle the word carrying m_eop is accepted (m_valid && m_ready). burst_cnt increments in that same cycle.
- Timer: increments in IDLE while 0 < lvl < BURST_LEN; saturates at TIMEOUT_CYC. Clears when lvl = 0, when lvl >= BURST_LEN, or on burst start.
- Read issue, BURST only: fifo_rdreq = !fifo_rdempty && issued < blen && credit > 0.
  - credit = 2 - (buffer occupancy) - (reads in flight).
  - No read is ever issued without buffer space, so m_ready may drop at any cycle with no loss.
- Latency: rdreq in cycle N -> fifo_q captured at the end of cycle N+1 -> m_valid high in cycle N+2 (buffer empty, no backpressure). Sustained throughput is 1 word/cycle while m_ready = 1.
- Output: a 2-entry FIFO-ordered buffer.
  - m_data/m_valid/m_sop/m_eop hold stable while m_valid && !m_ready.
  - m_sop marks sent == 0; m_eop marks sent == blen-1. blen == 1 gives both on the same word.
- Deasserting enable mid-burst does not truncate the burst; it only blocks the next start.
- Transient fifo_rdempty during BURST stalls rdreq; no timeout applies inside a burst.
- full_seen: set on any cycle with fifo_rdfull = 1. clr_full_seen clears it. Set wins when both occur in the same cycle.
- busy = (state != IDLE).

Decomposition:
- Package fifo_ctrl_pkg holds:
  - enum rd_state_t {IDLE, BURST, DRAIN}
  - localparams for DATA_W and USEDW_W
  - a function eff_level(usedw, full) returning USEDW_W+1 bits
- One sub-module, fifo_out_skid: the 2-entry valid/ready buffer carrying {sop, eop, data}, with an occupancy output used for the credit calculation.

Test Plan:
- Preload 40 words, enable=1, m_ready=1 -> one 32-word burst: first rdreq to first m_valid = 2 cycles; m_sop on word 0, m_eop on word 31; burst_cnt=1; 8 words remain.
- 8 words remain, no writes -> timer reaches 1024 -> 8-word burst with m_sop on word 0, m_eop on word 7; burst_cnt=2.
- 32-word burst with m_ready toggled by an LFSR -> all 32 words delivered in order, none duplicated, m_data stable during stalls; fifo_rdreq never issued when credit = 0.
- FIFO full (rdusedw=0, rdfull=1) -> treated as 256 words; a 32-word burst starts; full_seen=1; clr_full_seen pulse -> 0; simultaneous rdfull and clr -> full_seen stays 1.
- Exactly 1 word with TIMEOUT_CYC expiring -> a single word carrying m_sop=m_eop=1.
- aclr_n pulsed low at word 10 of a burst -> all outputs 0 immediately; after release the block is in IDLE and the next burst starts cleanly from the remaining FIFO level.
